// File: rtl/spi_command_ctrl.sv
// spi_command_ctrl
//   Decodes SPI command bytes and bridges them to the coax RX FIFO, the coax
//   TX FIFO and a small register file (status, control, optional device ID).
//
//   Optional feature macro: CTRL_DEVICE_ID_EN
//     defined   -> register 0xF reads DEVICE_ID
//     undefined -> register 0xF reads 0x00 (DEVICE_ID unused)
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   spi_cs                high = deselected, forces IDLE
//   spi_rx_data/_strobe   received SPI byte and its one-cycle valid pulse
//   spi_tx_data/_strobe   next byte to shift out and its one-cycle load pulse
//   ctrl_reg              control register (bit0 loopback, bit1 tx_parity_odd)
//   tx_data/_load_strobe  word and push pulse towards the TX FIFO
//   tx_full, tx_active    TX FIFO full, transmitter busy
//   tx_reset, rx_reset    one-cycle TX / RX reset pulses
//   rx_active, rx_error   receiver busy, receiver error
//   rx_data, rx_empty     RX FIFO head word, RX FIFO empty
//   rx_read_strobe        one-cycle RX FIFO dequeue
module spi_command_ctrl #(
    parameter int unsigned RX_WIDTH  = 10,
    parameter int unsigned TX_WIDTH  = 10,
    parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_cs,
    input  logic [7:0]          spi_rx_data,
    input  logic                spi_rx_strobe,
    output logic [7:0]          spi_tx_data,
    output logic                spi_tx_strobe,
    output logic [7:0]          ctrl_reg,
    output logic [TX_WIDTH-1:0] tx_data,
    output logic                tx_load_strobe,
    input  logic                tx_full,
    input  logic                tx_active,
    output logic                tx_reset,
    output logic                rx_reset,
    input  logic                rx_active,
    input  logic                rx_error,
    input  logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_read_strobe,
    input  logic                rx_empty
);

    typedef enum logic [3:0] {
        IDLE,
        READ_REG_1,
        READ_REG_2,
        WRITE_REG,
        TX_HI,
        TX_LO,
        RX_1,
        RX_2,
        RX_3,
        RX_4,
        RESET_CMD
    } state_t;

    localparam int unsigned HI_W = TX_WIDTH - 8;

    state_t            state, state_d;
    logic [3:0]        arg, arg_d;
    logic [HI_W-1:0]   tx_hi, tx_hi_d;
    logic [15:0]       rx_buf, rx_buf_d;
    logic              tx_overflow, tx_overflow_d;
    logic              ovf_set, ovf_clr;

    logic [7:0]          spi_tx_data_d;
    logic                spi_tx_strobe_d;
    logic [7:0]          ctrl_reg_d;
    logic [TX_WIDTH-1:0] tx_data_d;
    logic                tx_load_strobe_d;
    logic                tx_reset_d;
    logic                rx_reset_d;
    logic                rx_read_strobe_d;

    logic [7:0] status;
    logic [7:0] reg_rdata;

    assign status = {tx_overflow, rx_error, rx_active, tx_active, tx_full, 2'b00, rx_empty};

    always_comb begin
        case (arg)
            4'h1:    reg_rdata = status;
            4'h2:    reg_rdata = ctrl_reg;
`ifdef CTRL_DEVICE_ID_EN
            4'hF:    reg_rdata = DEVICE_ID;
`else
            4'hF:    reg_rdata = 8'h00;
`endif
            default: reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d          = state;
        arg_d            = arg;
        tx_hi_d          = tx_hi;
        rx_buf_d         = rx_buf;
        ovf_set          = 1'b0;
        ovf_clr          = 1'b0;
        spi_tx_data_d    = spi_tx_data;
        spi_tx_strobe_d  = 1'b0;
        ctrl_reg_d       = ctrl_reg;
        tx_data_d        = tx_data;
        tx_load_strobe_d = 1'b0;
        tx_reset_d       = 1'b0;
        rx_reset_d       = 1'b0;
        rx_read_strobe_d = 1'b0;

        case (state)
            IDLE: begin
                if (spi_rx_strobe) begin
                    arg_d = spi_rx_data[7:4];
                    case (spi_rx_data[3:0])
                        4'h2:    state_d = READ_REG_1;
                        4'h3:    state_d = WRITE_REG;
                        4'h4:    state_d = TX_HI;
                        4'h5:    state_d = RX_1;
                        4'h6:    state_d = RESET_CMD;
                        default: state_d = IDLE;
                    endcase
                end
            end
            READ_REG_1: begin
                spi_tx_data_d   = reg_rdata;
                spi_tx_strobe_d = 1'b1;
                ovf_clr         = (arg == 4'h1);
                state_d         = READ_REG_2;
            end
            READ_REG_2: begin
                if (spi_rx_strobe) state_d = READ_REG_1;
            end
            WRITE_REG: begin
                if (spi_rx_strobe) begin
                    if (arg == 4'h2) ctrl_reg_d = spi_rx_data;
                    state_d = IDLE;
                end
            end
            TX_HI: begin
                if (spi_rx_strobe) begin
                    tx_hi_d = spi_rx_data[HI_W-1:0];
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (spi_rx_strobe) begin
                    tx_data_d = {tx_hi, spi_rx_data};
                    if (tx_full) ovf_set = 1'b1;
                    else         tx_load_strobe_d = 1'b1;
                    state_d = TX_HI;
                end
            end
            RX_1: begin
                // Snapshot flags and head word together so both bytes describe one word.
                rx_buf_d               = '0;
                rx_buf_d[RX_WIDTH-1:0] = rx_data;
                rx_buf_d[15]           = rx_error;
                rx_buf_d[14]           = rx_empty;
                state_d                = RX_2;
            end
            RX_2: begin
                spi_tx_data_d   = rx_buf[15:8];
                spi_tx_strobe_d = 1'b1;
                state_d         = RX_3;
            end
            RX_3: begin
                if (spi_rx_strobe) begin
                    spi_tx_data_d   = rx_buf[7:0];
                    spi_tx_strobe_d = 1'b1;
                    if (rx_buf[15])      rx_reset_d       = 1'b1;
                    else if (!rx_buf[14]) rx_read_strobe_d = 1'b1;
                    state_d = RX_4;
                end
            end
            RX_4: begin
                if (spi_rx_strobe) state_d = RX_1;
            end
            RESET_CMD: begin
                rx_reset_d = 1'b1;
                tx_reset_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Deselect only redirects the state; output pulses computed above still go out.
        if (spi_cs) state_d = IDLE;

        // A new overflow outranks the clear-on-read.
        tx_overflow_d = ovf_set | (tx_overflow & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            arg            <= '0;
            tx_hi          <= '0;
            rx_buf         <= '0;
            tx_overflow    <= 1'b0;
            spi_tx_data    <= '0;
            spi_tx_strobe  <= 1'b0;
            ctrl_reg       <= '0;
            tx_data        <= '0;
            tx_load_strobe <= 1'b0;
            tx_reset       <= 1'b0;
            rx_reset       <= 1'b0;
            rx_read_strobe <= 1'b0;
        end else begin
            state          <= state_d;
            arg            <= arg_d;
            tx_hi          <= tx_hi_d;
            rx_buf         <= rx_buf_d;
            tx_overflow    <= tx_overflow_d;
            spi_tx_data    <= spi_tx_data_d;
            spi_tx_strobe  <= spi_tx_strobe_d;
            ctrl_reg       <= ctrl_reg_d;
            tx_data        <= tx_data_d;
            tx_load_strobe <= tx_load_strobe_d;
            tx_reset       <= tx_reset_d;
            rx_reset       <= rx_reset_d;
            rx_read_strobe <= rx_read_strobe_d;
        end
    end

endmodule

// File: tb/tb_spi_command_ctrl.sv
// Directed testbench for spi_command_ctrl (RX_WIDTH = TX_WIDTH = 10).
// Honours CTRL_DEVICE_ID_EN for the expected value of register 0xF.
module tb_spi_command_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic [7:0] spi_tx_data;
    logic       spi_tx_strobe;
    logic [7:0] ctrl_reg;
    logic [9:0] tx_data;
    logic       tx_load_strobe;
    logic       tx_full;
    logic       tx_active;
    logic       tx_reset;
    logic       rx_reset;
    logic       rx_active;
    logic       rx_error;
    logic [9:0] rx_data;
    logic       rx_read_strobe;
    logic       rx_empty;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] cap[$];
    int         n_load = 0;
    int         n_rd   = 0;
    int         n_rxr  = 0;
    int         n_txr  = 0;
    int         n_both = 0;
    logic [9:0] last_tx = '0;

    spi_command_ctrl #(
        .RX_WIDTH (10),
        .TX_WIDTH (10),
        .DEVICE_ID(8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_cs        (spi_cs),
        .spi_rx_data   (spi_rx_data),
        .spi_rx_strobe (spi_rx_strobe),
        .spi_tx_data   (spi_tx_data),
        .spi_tx_strobe (spi_tx_strobe),
        .ctrl_reg      (ctrl_reg),
        .tx_data       (tx_data),
        .tx_load_strobe(tx_load_strobe),
        .tx_full       (tx_full),
        .tx_active     (tx_active),
        .tx_reset      (tx_reset),
        .rx_reset      (rx_reset),
        .rx_active     (rx_active),
        .rx_error      (rx_error),
        .rx_data       (rx_data),
        .rx_read_strobe(rx_read_strobe),
        .rx_empty      (rx_empty)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (spi_tx_strobe) cap.push_back(spi_tx_data);
        if (tx_load_strobe) begin
            n_load++;
            last_tx = tx_data;
        end
        if (rx_read_strobe) n_rd++;
        if (rx_reset) n_rxr++;
        if (tx_reset) n_txr++;
        if (rx_reset && tx_reset) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic deselect();
        @(negedge clk);
        spi_cs = 1'b1;
        @(negedge clk);
        spi_cs = 1'b0;
    endtask

    int base;
    int b_load, b_rd, b_rxr, b_txr, b_both;
    logic [7:0] exp_id;

    initial begin
        reset = 1'b1;
        spi_cs = 1'b0;
        spi_rx_data = '0;
        spi_rx_strobe = 1'b0;
        tx_full = 1'b0;
        tx_active = 1'b0;
        rx_active = 1'b0;
        rx_error = 1'b0;
        rx_data = '0;
        rx_empty = 1'b0;

        #3;
        chk("reset_outputs",
            {1'b0, spi_tx_data, spi_tx_strobe, ctrl_reg, tx_data, tx_load_strobe, tx_reset, rx_reset, rx_read_strobe},
            32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write ctrl_reg then read it back twice by clocking bytes
        send(8'h23);
        send(8'h03);
        idle(1);
        chk("ctrl_write", ctrl_reg, 8'h03);
        base = cap.size();
        send(8'h22);
        send(8'h00);
        send(8'h00);
        idle(3);
        chk("read_ctrl_count", cap.size() - base, 3);
        chk("read_ctrl_b0", cap[base], 8'h03);
        chk("read_ctrl_b1", cap[base+1], 8'h03);
        chk("read_ctrl_b2", cap[base+2], 8'h03);
        deselect();

        // Write to a register other than 2 is ignored
        send(8'h53);
        send(8'hFF);
        idle(1);
        chk("write_other_ignored", ctrl_reg, 8'h03);

        // TX word load, then overflow on full FIFO
        b_load = n_load;
        send(8'h04);
        send(8'h02);
        send(8'h5A);
        idle(2);
        chk("tx_load_count", n_load - b_load, 1);
        chk("tx_data_word", last_tx, 10'h25A);
        tx_full = 1'b1;
        send(8'h01);
        send(8'h23);
        idle(2);
        chk("tx_full_no_load", n_load - b_load, 1);
        tx_full = 1'b0;
        deselect();

        // Status read: overflow reported once then cleared
        rx_empty = 1'b1;
        base = cap.size();
        send(8'h12);
        idle(2);
        send(8'h00);
        idle(2);
        chk("status_count", cap.size() - base, 2);
        chk("status_ovf_set", cap[base], 8'h81);
        chk("status_ovf_clr", cap[base+1], 8'h01);
        deselect();

        // Status bit placement
        rx_error = 1'b1;
        rx_active = 1'b1;
        tx_full = 1'b1;
        rx_empty = 1'b0;
        base = cap.size();
        send(8'h12);
        idle(2);
        chk("status_bits", cap[base], 8'h68);
        deselect();
        rx_error = 1'b0;
        rx_active = 1'b0;
        tx_full = 1'b0;
        tx_active = 1'b1;
        base = cap.size();
        send(8'h12);
        idle(2);
        chk("status_tx_active", cap[base], 8'h10);
        deselect();
        tx_active = 1'b0;

        // RX word, normal dequeue
        rx_data = 10'h155;
        b_rd = n_rd;
        b_rxr = n_rxr;
        base = cap.size();
        send(8'h05);
        idle(2);
        send(8'h00);
        idle(2);
        chk("rx_count", cap.size() - base, 2);
        chk("rx_hi", cap[base], 8'h01);
        chk("rx_lo", cap[base+1], 8'h55);
        chk("rx_read_pulse", n_rd - b_rd, 1);
        chk("rx_no_reset", n_rxr - b_rxr, 0);
        deselect();

        // RX with FIFO empty: no dequeue
        rx_empty = 1'b1;
        b_rd = n_rd;
        base = cap.size();
        send(8'h05);
        idle(2);
        send(8'h00);
        idle(2);
        chk("rx_empty_hi", cap[base], 8'h41);
        chk("rx_empty_lo", cap[base+1], 8'h55);
        chk("rx_empty_no_read", n_rd - b_rd, 0);
        deselect();

        // RX with error: rx_reset instead of dequeue
        rx_empty = 1'b0;
        rx_error = 1'b1;
        b_rd = n_rd;
        b_rxr = n_rxr;
        base = cap.size();
        send(8'h05);
        idle(2);
        send(8'h00);
        idle(2);
        chk("rx_err_hi", cap[base], 8'h81);
        chk("rx_err_lo", cap[base+1], 8'h55);
        chk("rx_err_reset", n_rxr - b_rxr, 1);
        chk("rx_err_no_read", n_rd - b_rd, 0);
        deselect();
        rx_error = 1'b0;

        // RESET command
        b_rxr = n_rxr;
        b_txr = n_txr;
        b_both = n_both;
        send(8'h06);
        idle(2);
        chk("reset_cmd_both", n_both - b_both, 1);
        chk("reset_cmd_rx", n_rxr - b_rxr, 1);
        chk("reset_cmd_tx", n_txr - b_txr, 1);

        // Deselect in TX_LO discards the half word and returns to IDLE
        b_load = n_load;
        send(8'h04);
        send(8'h03);
        deselect();
        send(8'h77);
        idle(2);
        chk("cs_abort_no_load", n_load - b_load, 0);
        base = cap.size();
        send(8'h22);
        idle(2);
        chk("cs_abort_idle_count", cap.size() - base, 1);
        chk("cs_abort_idle_read", cap[base], 8'h03);
        deselect();

        // Device ID register
`ifdef CTRL_DEVICE_ID_EN
        exp_id = 8'hA5;
`else
        exp_id = 8'h00;
`endif
        base = cap.size();
        send(8'hF2);
        idle(2);
        chk("device_id", cap[base], exp_id);
        deselect();

        // Asynchronous reset in the middle of an RX burst
        rx_error = 1'b1;
        send(8'h05);
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {1'b0, spi_tx_data, spi_tx_strobe, ctrl_reg, tx_data, tx_load_strobe, tx_reset, rx_reset, rx_read_strobe},
            32'h0);
        @(negedge clk);
        reset = 1'b0;
        rx_error = 1'b0;
        base = cap.size();
        send(8'h22);
        idle(2);
        chk("post_reset_count", cap.size() - base, 1);
        chk("post_reset_ctrl", cap[base], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
